addsub_pipe: RTL
================

Name: addsub_pipe

Overview:
- Multi-lane, parametrised successor of the team's single-cycle start/valid adder.
- Accepts a vector of LANES operand pairs plus an opcode through a valid/ready handshake.
- Computes per-lane add/sub with optional unsigned saturation, and delivers the result through a STAGES-deep pipeline that stalls under backpressure.
- Keeps sticky per-lane overflow status and reports pipeline occupancy. Sits between operand producers and downstream consumers in the datapath test designs.

Parameters:
- W, 10, operand/result width per lane (W >= 2).
- LANES, 4, number of independent lanes (LANES >= 1).
- STAGES, 2, pipeline depth in cycles (STAGES >= 1); STAGES=1 reproduces start |=> valid timing.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  pipeline can accept this cycle.
- op  in  2  opcode: 00 ADD, 01 SUB, 10 ADDS (saturating), 11 SUBS (saturating).
- a  in  LANES*W  packed lane operands A; lane i = a[i*W +: W].
- b  in  LANES*W  packed lane operands B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  LANES*W  packed lane results.
- ovf  out  LANES  per-lane overflow/borrow flag of the current result.
- ovf_sticky  out  LANES  per-lane OR of all ovf flags handed off since the last clear.
- clr_sticky  in  1  synchronous clear of ovf_sticky.
- occupancy  out  $clog2(STAGES+1)  number of valid pipeline stages.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits, y, ovf, ovf_sticky and occupancy go to 0; in_ready=1 once the reset state is held.
  - In-flight transactions are discarded and never appear after release.
- Handshake:
  - Acceptance = in_valid && in_ready at a rising edge.
  - Handoff = out_valid && out_ready at a rising edge.
  - While out_valid=1 and out_ready=0, y and ovf hold stable.
- Pipeline:
  - STAGES registered stages, s0..s(STAGES-1); stage s(STAGES-1) drives the outputs.
  - Stage k advances when it is empty, or when stage k+1 advances or is empty. The last stage advances when it is empty or on a handoff.
  - in_ready = s0 will advance; ready is combinational from out_ready.
  - Bubbles collapse. Full throughput of 1 transaction/cycle when out_ready=1.
- Latency: an acceptance at edge k with no stall gives out_valid=1 in the cycle after edge k+STAGES-1.
- Arithmetic: done before the s0 register, per lane, unsigned on W+1 bits.
  - ADD: y = (a+b) mod 2^W; ovf = carry out.
  - SUB: y = (a-b) mod 2^W; ovf = borrow (a<b).
  - ADDS: on carry, y = 2^W-1, else the sum; ovf = carry.
  - SUBS: on borrow, y = 0, else the difference; ovf = borrow.
- Sticky status:
  - On each handoff, ovf_sticky |= ovf.
  - If clr_sticky and a handoff occur in the same cycle, ovf_sticky = ovf of that handoff (clear first, then OR).
- Occupancy: count of set stage valid bits; 0..STAGES; registered.
- Ordering: strictly in order; no loss or duplication under any out_ready pattern.
- No-X rule: out_valid must never be X after reset; y may be don't-care only while out_valid=0.

Decomposition:
- Package addsub_pkg:
  - op_e enum (OP_ADD, OP_SUB, OP_ADDS, OP_SUBS).
  - OP_W=2.
  - Per-stage struct template fields: valid, op-independent result, ovf.
- Sub-module addsub_lane: one lane's W-bit arithmetic and saturation. Combinational; instantiated LANES times via generate.
- The stage array, handshake and sticky logic live in addsub_pipe.

Test Plan (W=10, LANES=4, STAGES=2):
1. Reset: hold rst_n low 3 cycles with in_valid=1 -> out_valid=0, ovf_sticky=0, occupancy=0 throughout; in_ready=1 after release.
2. ADD, lane0 a=100 b=200, out_ready=1 -> y lane0=300, ovf=0; out_valid high exactly 2 cycles after acceptance, for one cycle.
3. ADD lane1 1000+100 -> y=76, ovf[1]=1. ADDS with the same operands -> y=1023, ovf[1]=1. ovf_sticky[1]=1 until a clr_sticky pulse, then 0.
4. SUB lane2 5-10 -> y=1019, ovf[2]=1. SUBS 5-10 -> y=0. SUB 10-5 -> y=5, ovf=0.
5. Backpressure: out_ready=0, offer 4 back-to-back transactions -> exactly 2 accepted, in_ready=0, occupancy=2, y stable. Raise out_ready -> all 4 emerge in order, none lost or duplicated.
6. Reset mid-flight: 2 transactions in the pipe, pulse rst_n low between clock edges -> out_valid drops immediately; no stale result after release; ovf_sticky=0.

Source files
------------

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared opcode type for the addsub_pipe datapath
//
// Purpose: opcode encoding used by the lane arithmetic and the pipeline top.
// Contents:
//   OP_W  opcode width
//   op_e  ADD / SUB wrap around modulo 2^W, ADDS / SUBS saturate
// The per-stage record (valid, lane results, lane ovf) depends on the
// W/LANES parameters, so it is declared as stage_t inside addsub_pipe.
package addsub_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDS = 2'b10,
    OP_SUBS = 2'b11
  } op_e;

endpackage

// File: rtl/addsub_lane.sv
// rtl/addsub_lane.sv - one lane of W-bit add/sub with optional unsigned saturation
//
// Purpose: combinational arithmetic for a single lane, evaluated on W+1 bits.
// Ports:
//   i_a, i_b  in   W     unsigned operands
//   i_op      in   OP_W  opcode (op_e encoding)
//   o_y       out  W     lane result
//   o_ovf     out  1     carry (add) or borrow (sub)
module addsub_lane
  import addsub_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0]    i_a,
  input  logic [W-1:0]    i_b,
  input  logic [OP_W-1:0] i_op,
  output logic [W-1:0]    o_y,
  output logic            o_ovf
);

  logic [W:0] w_sum;
  logic [W:0] w_dif;
  op_e        w_op;

  assign w_op  = op_e'(i_op);
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  // Bit W of the extended difference is set exactly when a < b.
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_y   = w_sum[W-1:0];
    o_ovf = w_sum[W];
    case (w_op)
      OP_ADD: begin
        o_y   = w_sum[W-1:0];
        o_ovf = w_sum[W];
      end
      OP_SUB: begin
        o_y   = w_dif[W-1:0];
        o_ovf = w_dif[W];
      end
      OP_ADDS: begin
        o_y   = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
        o_ovf = w_sum[W];
      end
      OP_SUBS: begin
        o_y   = w_dif[W] ? {W{1'b0}} : w_dif[W-1:0];
        o_ovf = w_dif[W];
      end
      default: begin
        o_y   = w_sum[W-1:0];
        o_ovf = w_sum[W];
      end
    endcase
  end

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - multi-lane add/sub behind a stallable STAGES-deep pipeline
//
// Purpose: accepts LANES operand pairs plus an opcode per valid/ready
// transaction, computes per-lane results before the s0 register and carries
// them through STAGES registered stages with collapsing bubbles.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input handshake; in_ready is combinational from out_ready
//   op                opcode (addsub_pkg::op_e)
//   a, b              packed operands, lane i = [i*W +: W]
//   out_valid/out_ready output handshake
//   y, ovf            packed lane results and per-lane carry/borrow
//   ovf_sticky        per-lane OR of ovf over handoffs since clr_sticky
//   clr_sticky        synchronous clear of ovf_sticky (clear, then OR)
//   occupancy         number of valid stages, registered
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int W      = 10,
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_W-1:0]              op,
  input  logic [LANES*W-1:0]           a,
  input  logic [LANES*W-1:0]           b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*W-1:0]           y,
  output logic [LANES-1:0]             ovf,
  output logic [LANES-1:0]             ovf_sticky,
  input  logic                         clr_sticky,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OCC_W = $clog2(STAGES + 1);

  typedef struct packed {
    logic                 vld;
    logic [LANES*W-1:0]   y;
    logic [LANES-1:0]     ovf;
  } stage_t;

  stage_t               r_st [STAGES];
  logic [LANES-1:0]     r_sticky;
  logic [OCC_W-1:0]     r_occ;

  logic [LANES*W-1:0]   w_y;
  logic [LANES-1:0]     w_ovf;
  logic [STAGES-1:0]    w_vld;
  logic [STAGES-1:0]    w_adv;
  logic                 w_acc;
  logic                 w_ho;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    addsub_lane #(.W(W)) u_lane (
      .i_a   (a[g*W +: W]),
      .i_b   (b[g*W +: W]),
      .i_op  (op),
      .o_y   (w_y[g*W +: W]),
      .o_ovf (w_ovf[g])
    );
  end

  // Stage k can move when the consumer drains the last stage or when any
  // stage from k to the end is empty (that hole absorbs the shift).
  // Written in closed form so the ready chain has no self-referencing net.
  always_comb begin
    w_vld = '0;
    w_adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_vld[k] = r_st[k].vld;
    end
    for (int k = 0; k < STAGES; k++) begin
      w_adv[k] = out_ready || !(&(w_vld | STAGES'((64'd1 << k) - 64'd1)));
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_st[STAGES-1].vld;
  assign y         = r_st[STAGES-1].y;
  assign ovf       = r_st[STAGES-1].ovf;
  assign w_acc     = in_valid && in_ready;
  assign w_ho      = out_valid && out_ready;

  assign ovf_sticky = r_sticky;
  assign occupancy  = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_st[k] <= '0;
      end
      r_sticky <= '0;
      r_occ    <= '0;
    end else begin
      if (w_adv[0]) begin
        r_st[0] <= '{vld: in_valid, y: w_y, ovf: w_ovf};
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_st[k] <= r_st[k-1];
        end
      end
      // Clear takes effect before the OR of the simultaneous handoff.
      if (w_ho) begin
        r_sticky <= (clr_sticky ? '0 : r_sticky) | r_st[STAGES-1].ovf;
      end else if (clr_sticky) begin
        r_sticky <= '0;
      end
      r_occ <= r_occ + OCC_W'(w_acc) - OCC_W'(w_ho);
    end
  end

endmodule
